// File: rtl/chiplet_job_dispatcher.sv
// Dispatches a stream of {id,size} jobs to the least-loaded chiplet row that has credit.
// Each row keeps an in-flight count: a fire increments it and a completion strobe decrements it.
module chiplet_job_dispatcher #(
   parameter  int id_width_p        = 8,
   parameter  int size_width_p      = 8,
   parameter  int num_rows_p        = 2,
   parameter  int max_outstanding_p = 4,
   localparam int width_p           = id_width_p + size_width_p,
   localparam int cnt_w             = $clog2(max_outstanding_p + 1)
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          v_i,
   input  logic [width_p-1:0]            data_i,
   output logic                          ready_o,
   output logic [num_rows_p-1:0]         row_v_o,
   output logic [num_rows_p*width_p-1:0] row_data_o,
   input  logic [num_rows_p-1:0]         row_ready_i,
   input  logic [num_rows_p-1:0]         done_v_i,
   output logic [num_rows_p*cnt_w-1:0]   outstanding_o,
   output logic                          busy_o,
   output logic                          error_o
);

   localparam int sel_w = (num_rows_p > 1) ? $clog2(num_rows_p) : 1;

   typedef enum logic [1:0] {ST_EMPTY, ST_PEND, ST_OFFER} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [width_p-1:0]      r_hold;
   logic [sel_w-1:0]        r_sel;
   logic [sel_w-1:0]        r_rr;
   logic [cnt_w-1:0]        r_cnt [num_rows_p];
   logic                    r_error;
   logic                    w_accept;
   logic                    w_fire;
   logic                    w_pick_v;
   logic [sel_w-1:0]        w_pick;
   logic [cnt_w-1:0]        w_best;
   logic [num_rows_p-1:0]   w_inc;
   logic [num_rows_p-1:0]   w_zero;

   assign w_accept = v_i & ready_o;
   assign w_fire   = (r_state == ST_OFFER) & row_ready_i[r_sel];

   // NOTE: flops use <= so every register samples pre-edge values; comb blocks use = with defaults first.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) r_state <= ST_EMPTY;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_EMPTY: if (w_accept) w_state_nxt = ST_PEND;
         ST_PEND:  if (w_pick_v) w_state_nxt = ST_OFFER;
         ST_OFFER: if (w_fire)   w_state_nxt = w_accept ? ST_PEND : ST_EMPTY;
         default:                w_state_nxt = ST_EMPTY;
      endcase
   end

   always_comb begin
      ready_o = 1'b0;
      row_v_o = '0;
      unique case (r_state)
         ST_EMPTY: ready_o = 1'b1;
         ST_OFFER: begin
            ready_o        = row_ready_i[r_sel];
            row_v_o[r_sel] = 1'b1;
         end
         default: ;
      endcase
   end

   // Scan from rr_ptr; strict '<' keeps the first minimum found, giving the round-robin tie-break.
   always_comb begin : pick_row
      int               v_idx;
      logic [sel_w-1:0] v_row;
      v_idx    = 0;
      v_row    = '0;
      w_pick_v = 1'b0;
      w_pick   = '0;
      w_best   = '0;
      for (int k = 0; k < num_rows_p; k++) begin
         v_idx = (int'(r_rr) + k) % num_rows_p;
         v_row = sel_w'(v_idx);
         if ((r_cnt[v_row] < cnt_w'(max_outstanding_p)) &&
             (!w_pick_v || (r_cnt[v_row] < w_best))) begin
            w_pick_v = 1'b1;
            w_pick   = v_row;
            w_best   = r_cnt[v_row];
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_hold <= '0;
         r_sel  <= '0;
         r_rr   <= '0;
      end else begin
         if (w_accept)                         r_hold <= data_i;
         if ((r_state == ST_PEND) && w_pick_v) r_sel  <= w_pick;
         if (w_fire) r_rr <= (r_sel == sel_w'(num_rows_p - 1)) ? '0 : r_sel + 1'b1;
      end
   end

   always_comb begin
      w_inc = '0;
      if (w_fire) w_inc[r_sel] = 1'b1;
   end

   // NOTE: the count array is a handful of flops, not a RAM, so it is cleared by the async reset.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int r = 0; r < num_rows_p; r++) r_cnt[r] <= '0;
         r_error <= 1'b0;
      end else begin
         for (int r = 0; r < num_rows_p; r++) begin
            if (w_inc[r] && !done_v_i[r])
               r_cnt[r] <= r_cnt[r] + 1'b1;
            else if (!w_inc[r] && done_v_i[r] && !w_zero[r])
               r_cnt[r] <= r_cnt[r] - 1'b1;
         end
         if (|(done_v_i & ~w_inc & w_zero)) r_error <= 1'b1;
      end
   end

   for (genvar r = 0; r < num_rows_p; r++) begin : g_row
      assign w_zero[r]                          = (r_cnt[r] == '0);
      assign outstanding_o[r*cnt_w +: cnt_w]    = r_cnt[r];
      assign row_data_o[r*width_p +: width_p]   = r_hold;
   end

   assign busy_o  = (r_state != ST_EMPTY) | ~(&w_zero);
   assign error_o = r_error;

endmodule

// File: tb/tb_chiplet_job_dispatcher.sv
// Directed scenarios plus a randomized run scored against a transaction-level model
// of the dispatcher (held job, chosen row, per-row counts, round-robin pointer).
module tb_chiplet_job_dispatcher;

   localparam int NR  = 2;
   localparam int MAX = 4;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        v_i;
   logic [15:0] data_i;
   logic        ready_o;
   logic [1:0]  row_v_o;
   logic [31:0] row_data_o;
   logic [1:0]  row_ready_i;
   logic [1:0]  done_v_i;
   logic [5:0]  outstanding_o;
   logic        busy_o;
   logic        error_o;

   int errors = 0;
   int checks = 0;

   int          fire_row_q  [$];
   logic [15:0] fire_data_q [$];

   // model state
   bit          m_held;
   int          m_sel;
   logic [15:0] m_data;
   int          m_cnt [NR];
   int          m_rr;
   bit          m_err;

   chiplet_job_dispatcher dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .v_i          (v_i),
      .data_i       (data_i),
      .ready_o      (ready_o),
      .row_v_o      (row_v_o),
      .row_data_o   (row_data_o),
      .row_ready_i  (row_ready_i),
      .done_v_i     (done_v_i),
      .outstanding_o(outstanding_o),
      .busy_o       (busy_o),
      .error_o      (error_o)
   );

   always #5 clk_i = ~clk_i;

   // A fire is valid & ready on the offered row; logged mid-cycle, away from the edge.
   always @(negedge clk_i) begin
      if (!reset_i && ((row_v_o & row_ready_i) != 2'b00)) begin
         fire_row_q.push_back(row_v_o[1] ? 1 : 0);
         fire_data_q.push_back(row_v_o[1] ? row_data_o[31:16] : row_data_o[15:0]);
      end
   end

   function automatic logic [5:0] cnts(input int c0, input int c1);
      return {3'(c1), 3'(c0)};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic apply_reset();
      v_i      = 1'b0;
      done_v_i = 2'b00;
      reset_i  = 1'b1;
      tick();
      reset_i  = 1'b0;
      fire_row_q.delete();
      fire_data_q.delete();
   endtask

   // Present a job and hold it until accepted; returns one cycle after the accepting edge.
   task automatic send(input logic [15:0] d);
      int n;
      n      = 0;
      v_i    = 1'b1;
      data_i = d;
      #1;
      while (!ready_o && n < 50) begin
         @(posedge clk_i);
         #2;
         n++;
      end
      check("send_accept_in_time", 64'(n < 50), 64'd1);
      tick();
      v_i = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(ready_o && row_v_o == 2'b00) && n < 30) begin
         tick();
         n++;
      end
      check("idle_in_time", 64'(n < 30), 64'd1);
   endtask

   task automatic model_reset();
      m_held = 1'b0;
      m_sel  = -1;
      m_data = '0;
      m_rr   = 0;
      m_err  = 1'b0;
      for (int r = 0; r < NR; r++) m_cnt[r] = 0;
   endtask

   task automatic model_check(input int cyc);
      bit         exp_ready;
      logic [1:0] exp_rowv;
      exp_ready = !m_held || (m_sel >= 0 && row_ready_i[m_sel]);
      exp_rowv  = (m_sel >= 0) ? 2'(1 << m_sel) : 2'b00;
      check($sformatf("rnd%0d_ready", cyc), 64'(ready_o), 64'(exp_ready));
      check($sformatf("rnd%0d_row_v", cyc), 64'(row_v_o), 64'(exp_rowv));
      check($sformatf("rnd%0d_cnt", cyc), 64'(outstanding_o), 64'(cnts(m_cnt[0], m_cnt[1])));
      check($sformatf("rnd%0d_busy", cyc), 64'(busy_o),
            64'(m_held || m_cnt[0] != 0 || m_cnt[1] != 0));
      check($sformatf("rnd%0d_error", cyc), 64'(error_o), 64'(m_err));
      if (m_held)
         check($sformatf("rnd%0d_data", cyc), 64'(row_data_o), 64'({m_data, m_data}));
   endtask

   task automatic model_step();
      bit ready;
      bit fire;
      bit acc;
      bit inc;
      int pick;
      int r;
      ready = !m_held || (m_sel >= 0 && row_ready_i[m_sel]);
      fire  = (m_sel >= 0) && row_ready_i[m_sel];
      acc   = v_i && ready;
      pick  = -1;
      if (m_held && m_sel < 0) begin
         for (int k = 0; k < NR; k++) begin
            r = (m_rr + k) % NR;
            if (m_cnt[r] < MAX && (pick < 0 || m_cnt[r] < m_cnt[pick])) pick = r;
         end
      end
      for (int q = 0; q < NR; q++) begin
         inc = fire && (m_sel == q);
         if (inc && !done_v_i[q]) m_cnt[q]++;
         else if (!inc && done_v_i[q]) begin
            if (m_cnt[q] == 0) m_err = 1'b1;
            else               m_cnt[q]--;
         end
      end
      if (fire) begin
         m_rr   = (m_sel + 1) % NR;
         m_held = acc;
         m_sel  = -1;
      end else if (!m_held) begin
         m_held = acc;
      end else if (m_sel < 0) begin
         m_sel = pick;
      end
      if (acc) m_data = data_i;
   endtask

   initial begin
      reset_i     = 1'b1;
      v_i         = 1'b0;
      data_i      = '0;
      row_ready_i = 2'b00;
      done_v_i    = 2'b00;

      // 1: reset state, single job latency and data, completion
      apply_reset();
      check("rst_ready", 64'(ready_o), 64'd1);
      check("rst_row_v", 64'(row_v_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_error", 64'(error_o), 64'd0);
      check("rst_cnt", 64'(outstanding_o), 64'd0);
      row_ready_i = 2'b11;
      send(16'h0503);
      check("t1_no_offer_t1", 64'(row_v_o), 64'd0);
      tick();
      check("t1_offer_t2", 64'(row_v_o), 64'b01);
      check("t1_data", 64'(row_data_o[15:0]), 64'h0503);
      tick();
      check("t1_cnt_after_fire", 64'(outstanding_o), 64'(cnts(1, 0)));
      check("t1_busy", 64'(busy_o), 64'd1);
      done_v_i = 2'b01;
      tick();
      done_v_i = 2'b00;
      check("t1_cnt_after_done", 64'(outstanding_o), 64'd0);
      check("t1_idle", 64'(busy_o), 64'd0);

      // 2: back-to-back jobs alternate rows
      apply_reset();
      row_ready_i = 2'b11;
      for (int i = 1; i <= 4; i++) send(16'((i << 8) | 8'h10));
      wait_idle();
      check("t2_nfires", 64'(fire_row_q.size()), 64'd4);
      for (int i = 0; i < 4 && i < fire_row_q.size(); i++) begin
         check($sformatf("t2_row%0d", i), 64'(fire_row_q[i]), 64'(i % 2));
         check($sformatf("t2_data%0d", i), 64'(fire_data_q[i]), 64'(((i + 1) << 8) | 8'h10));
      end
      check("t2_cnt", 64'(outstanding_o), 64'(cnts(2, 2)));

      // 3: credit exhaustion, then a completion releases the held job to row 1
      apply_reset();
      row_ready_i = 2'b11;
      for (int i = 0; i < 8; i++) send(16'(16'h2000 + i));
      wait_idle();
      check("t3_full", 64'(outstanding_o), 64'(cnts(4, 4)));
      send(16'h2909);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("t3_held_row_v%0d", i), 64'(row_v_o), 64'd0);
         check($sformatf("t3_held_ready%0d", i), 64'(ready_o), 64'd0);
      end
      done_v_i = 2'b10;
      tick();
      done_v_i = 2'b00;
      check("t3_after_done_cnt", 64'(outstanding_o), 64'(cnts(4, 3)));
      check("t3_after_done_row_v", 64'(row_v_o), 64'd0);
      tick();
      check("t3_offer_row1", 64'(row_v_o), 64'b10);
      check("t3_offer_data", 64'(row_data_o[31:16]), 64'h2909);
      tick();
      check("t3_refill", 64'(outstanding_o), 64'(cnts(4, 4)));

      // 4: stalled offer stays put and ignores the other row's ready
      apply_reset();
      row_ready_i = 2'b10;
      send(16'h0742);
      tick();
      for (int i = 0; i < 5; i++) begin
         v_i    = 1'b1;
         data_i = 16'hBEEF;
         #1;
         check($sformatf("t4_row_v%0d", i), 64'(row_v_o), 64'b01);
         check($sformatf("t4_data%0d", i), 64'(row_data_o), 64'h0742_0742);
         check($sformatf("t4_ready%0d", i), 64'(ready_o), 64'd0);
         tick();
      end
      v_i         = 1'b0;
      row_ready_i = 2'b11;
      #1;
      check("t4_release_ready", 64'(ready_o), 64'd1);
      tick();
      check("t4_cnt", 64'(outstanding_o), 64'(cnts(1, 0)));
      check("t4_nfires", 64'(fire_row_q.size()), 64'd1);
      if (fire_data_q.size() > 0) check("t4_fire_data", 64'(fire_data_q[0]), 64'h0742);

      // 5: fire with simultaneous done, then done on an empty row
      apply_reset();
      row_ready_i = 2'b11;
      for (int i = 0; i < 4; i++) send(16'(16'h5000 + i));
      wait_idle();
      check("t5_start", 64'(outstanding_o), 64'(cnts(2, 2)));
      row_ready_i = 2'b10;
      send(16'h0505);
      tick();
      check("t5_offer_row0", 64'(row_v_o), 64'b01);
      row_ready_i = 2'b11;
      done_v_i    = 2'b01;
      tick();
      done_v_i    = 2'b00;
      check("t5_fire_and_done", 64'(outstanding_o), 64'(cnts(2, 2)));
      check("t5_no_error", 64'(error_o), 64'd0);
      done_v_i = 2'b10;
      tick();
      tick();
      done_v_i = 2'b00;
      check("t5_row1_drained", 64'(outstanding_o), 64'(cnts(2, 0)));
      check("t5_still_no_error", 64'(error_o), 64'd0);
      done_v_i = 2'b10;
      tick();
      done_v_i = 2'b00;
      check("t5_underflow_error", 64'(error_o), 64'd1);
      check("t5_row1_stays_zero", 64'(outstanding_o), 64'(cnts(2, 0)));
      tick();
      tick();
      check("t5_error_sticky", 64'(error_o), 64'd1);

      // 6: asynchronous reset in the middle of an offer
      row_ready_i = 2'b00;
      send(16'h0606);
      tick();
      check("t6_offer_row1", 64'(row_v_o), 64'b10);
      #2;
      reset_i = 1'b1;
      #1;
      check("t6_async_row_v", 64'(row_v_o), 64'd0);
      check("t6_async_cnt", 64'(outstanding_o), 64'd0);
      check("t6_async_error", 64'(error_o), 64'd0);
      check("t6_async_busy", 64'(busy_o), 64'd0);
      #2;
      reset_i = 1'b0;
      tick();
      fire_row_q.delete();
      fire_data_q.delete();
      row_ready_i = 2'b11;
      send(16'h0607);
      wait_idle();
      check("t6_nfires", 64'(fire_row_q.size()), 64'd1);
      if (fire_row_q.size() > 0) check("t6_row0", 64'(fire_row_q[0]), 64'd0);
      check("t6_cnt", 64'(outstanding_o), 64'(cnts(1, 0)));

      // randomized traffic against the model
      apply_reset();
      model_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         v_i         = ($urandom_range(0, 9) < 6);
         data_i      = 16'($urandom);
         row_ready_i = 2'($urandom);
         done_v_i    = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
         #1;
         model_check(cyc);
         model_step();
         @(posedge clk_i);
         #1;
      end
      v_i      = 1'b0;
      done_v_i = 2'b00;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
